neuron_activation: RTL
======================

Name: neuron_activation

Overview:
- Downstream stage of the N-input neuron MAC datapath/controller pair.
- Consumes the signed accumulated sum (16+clog2(N) bits) when the controller pulses ready.
- Adds bias, round-shifts right, applies optional ReLU and saturates to an 8-bit activation.
- Presents the activation to the next layer through a valid/ready handshake, with a one-entry pending buffer so ready pulses that arrive while busy are not lost.

Parameters:
- N, 2, neuron fan-in; must match the MAC stage.
- ACC_W, 16+clog2(N) (localparam, clog2(2)=1 so 17 at default), accumulator width.
- SHIFT, 7, right-shift (fixed-point rescale) amount, 0..ACC_W.
- RELU, 1, 1: output unsigned 0..255 with negatives forced to 0; 0: output signed two's complement -128..127.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- acc_valid  in  1  one-cycle pulse; acc_in/bias_in are valid (driven from the MAC controller ready).
- acc_in  in  ACC_W  signed accumulated sum.
- bias_in  in  ACC_W  signed bias.
- acc_ready  out  1  high in IDLE with pending buffer empty (informational; input is never back-pressured).
- out_valid  out  1  activation available.
- out_ready  in  1  downstream accepts.
- out_data  out  8  activation.
- sat_count  out  8  saturating count of clipped results.
- drop_err  out  1  sticky; a pulse was lost.

Behaviour:
- Reset (rst low, async): state=IDLE; out_valid=0; out_data=0; sat_count=0; drop_err=0; pending cleared; acc_ready=1. Reset mid-operation discards all in-flight and pending data.
- Internal sum register: ACC_W+2 bits, signed. All shifts are arithmetic.
- FSM states: IDLE, BIAS, SCALE, ACT, HOLD.
- IDLE:
  - If pending valid, load pending acc/bias into working regs, clear pending, go to BIAS.
  - Else if acc_valid, load acc_in/bias_in, go to BIAS.
  - If both hold, pending wins and the new acc_valid goes into pending.
- BIAS: sum = acc + bias + (SHIFT>0 ? 2^(SHIFT-1) : 0), i.e. round-half-up. Go to SCALE, or to ACT if SHIFT=0. Shift counter loaded with SHIFT.
- SCALE: sum >>>= 1 each cycle; counter decrements; after exactly SHIFT cycles go to ACT.
- ACT:
  - RELU=1: sum<0 -> 0; sum>255 -> 255; else sum[7:0].
  - RELU=0: clamp to [-128,127].
  - Any clamp of a nonzero-magnitude overflow (>255, or outside [-128,127]) increments sat_count, which stops at 255. ReLU zeroing of a negative is not a saturation.
  - Registers out_data, sets out_valid, goes to HOLD.
- HOLD:
  - out_valid and out_data are held stable until out_ready is sampled high.
  - On that edge out_valid=0 and state=IDLE; out_data keeps its last value.
- Latency: acc_valid sampled at edge E0 -> out_valid high after edge E0+SHIFT+2 (9 cycles at default). Minimum out_valid duration is 1 cycle when out_ready is already high.
- Pending buffer:
  - acc_valid in any non-IDLE state with pending empty -> store into pending.
  - acc_valid with pending full -> data dropped, pending unchanged, drop_err=1 until reset.
- acc_ready = (state==IDLE) && !pending_valid.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Basic: defaults; acc_in=1000, bias=0 -> 1000+64=1064, >>7 -> out_data=8; out_valid rises 9 cycles after the acc_valid edge; clears on out_ready.
- Negative/ReLU: acc_in=-500, bias=0 -> out_data=0, sat_count unchanged. Repeat with RELU=0 -> (-500+64)>>>7 = -4 -> out_data=0xFC.
- Saturation: acc_in=40000, bias=100 -> 40164>>7=313 -> out_data=255, sat_count=1. Repeat 300 times -> sat_count stays 255.
- Back-pressure and pending:
  - Hold out_ready=0; pulse acc_valid with 1000, then 2000 while busy.
  - First result 8 is held in HOLD. Raise out_ready -> second result (2064>>7=16) appears SHIFT+3 cycles later.
  - A third pulse while pending is full -> drop_err=1, only two outputs are produced.
- Simultaneous: acc_valid on the same edge IDLE consumes pending -> pending data processed first, new data stored, both emerge in order.
- Reset mid-operation: pull rst low during SCALE, release -> out_valid=0, sat_count=0, drop_err=0, acc_ready=1. The next transaction produces the correct result with normal latency.

Source files
------------

// File: rtl/neuron_activation.sv
// neuron_activation: back end of the N-input neuron pipeline.
// Takes the signed MAC sum plus a bias, applies round-half-up rescaling by an
// arithmetic right shift, then ReLU or signed clamping down to an 8-bit
// activation. The result is offered through a valid/ready handshake. A
// one-entry pending buffer catches accumulator pulses that arrive while a
// result is still in flight, because the MAC side is never stalled.

// Protocol properties that the datapath must keep on its output interface.
module neuron_activation_checker (
    input logic       clk,
    input logic       rst,
    input logic       acc_ready,
    input logic       out_valid,
    input logic       out_ready,
    input logic [7:0] out_data,
    input logic       drop_err
);

    // A stalled result must not change or disappear.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    // Being ready for new input implies nothing is being presented.
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst)
        acc_ready |-> !out_valid);

    // A lost pulse stays flagged until reset.
    a_drop_sticky: assert property (@(posedge clk) disable iff (!rst)
        drop_err |=> drop_err);

endmodule

module neuron_activation #(
    parameter  int N     = 2,
    parameter  int SHIFT = 7,
    parameter  int RELU  = 1,
    localparam int ACC_W = 16 + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_valid,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [ACC_W-1:0] bias_in,
    output logic             acc_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [7:0]       sat_count,
    output logic             drop_err
);

    // Two guard bits: acc + bias + rounding constant can never overflow.
    localparam int SUM_W    = ACC_W + 2;
    localparam int CNT_W    = $clog2(ACC_W + 1);
    localparam int ROUND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    // Half an LSB of the shifted result, giving round-half-up.
    localparam logic signed [SUM_W-1:0] ROUND_C =
        (SHIFT > 0) ? (SUM_W'(1) << ROUND_SH) : SUM_W'(0);

    // Clamp window of the final activation.
    localparam logic signed [SUM_W-1:0] LIM_HI = (RELU != 0) ? SUM_W'(255) : SUM_W'(127);
    localparam logic signed [SUM_W-1:0] LIM_LO = (RELU != 0) ? SUM_W'(0)   : SUM_W'(-128);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_SCALE = 3'd2,
        ST_ACT   = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Returns {saturated, activation}.
    // When ReLU is enabled, forcing a negative sum to zero is the intended
    // output and is not reported as a saturation.
    function automatic logic [8:0] activate(input logic signed [SUM_W-1:0] s);
        logic [8:0] r;
        if (s > LIM_HI) begin
            r = {1'b1, LIM_HI[7:0]};
        end else if (s < LIM_LO) begin
            if (RELU != 0) begin
                r = {1'b0, 8'h00};
            end else begin
                r = {1'b1, LIM_LO[7:0]};
            end
        end else begin
            r = {1'b0, s[7:0]};
        end
        return r;
    endfunction

    state_e                   state_q,      state_d;
    logic [ACC_W-1:0]         acc_q,        acc_d;
    logic [ACC_W-1:0]         bias_q,       bias_d;
    logic signed [SUM_W-1:0]  sum_q,        sum_d;
    logic [CNT_W-1:0]         cnt_q,        cnt_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [ACC_W-1:0]         pend_acc_q,   pend_acc_d;
    logic [ACC_W-1:0]         pend_bias_q,  pend_bias_d;
    logic                     out_valid_q,  out_valid_d;
    logic [7:0]               out_data_q,   out_data_d;
    logic [7:0]               sat_count_q,  sat_count_d;
    logic                     drop_err_q,   drop_err_d;

    logic signed [SUM_W-1:0]  acc_ext_s;
    logic signed [SUM_W-1:0]  bias_ext_s;
    logic [8:0]               act_s;

    // Sign-extend the working operands and evaluate the activation of the current sum.
    always_comb begin
        acc_ext_s  = {{(SUM_W - ACC_W){acc_q[ACC_W-1]}}, acc_q};
        bias_ext_s = {{(SUM_W - ACC_W){bias_q[ACC_W-1]}}, bias_q};
        act_s      = activate(sum_q);
    end

    // Next-state logic for the FSM, the datapath and the pending buffer.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        bias_d       = bias_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_acc_d   = pend_acc_q;
        pend_bias_d  = pend_bias_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        sat_count_d  = sat_count_q;
        drop_err_d   = drop_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    // Buffered work goes first. A pulse arriving on the same
                    // edge takes over the slot that is being emptied.
                    acc_d   = pend_acc_q;
                    bias_d  = pend_bias_q;
                    state_d = ST_BIAS;
                    if (acc_valid) begin
                        pend_valid_d = 1'b1;
                        pend_acc_d   = acc_in;
                        pend_bias_d  = bias_in;
                    end else begin
                        pend_valid_d = 1'b0;
                    end
                end else if (acc_valid) begin
                    acc_d   = acc_in;
                    bias_d  = bias_in;
                    state_d = ST_BIAS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BIAS: begin
                sum_d = acc_ext_s + bias_ext_s + ROUND_C;
                cnt_d = CNT_W'(SHIFT);
                if (SHIFT == 0) begin
                    state_d = ST_ACT;
                end else begin
                    state_d = ST_SCALE;
                end
            end

            ST_SCALE: begin
                // One bit per cycle keeps the shifter down to a single mux level.
                sum_d = sum_q >>> 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_ACT;
                end else begin
                    state_d = ST_SCALE;
                end
            end

            ST_ACT: begin
                out_data_d  = act_s[7:0];
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
                if (act_s[8] && (sat_count_q != 8'hFF)) begin
                    sat_count_d = sat_count_q + 8'd1;
                end else begin
                    sat_count_d = sat_count_q;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // While busy, a pulse is parked if the slot is free and is lost otherwise.
        if (acc_valid && (state_q != ST_IDLE)) begin
            if (!pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_acc_d   = acc_in;
                pend_bias_d  = bias_in;
            end else begin
                drop_err_d = 1'b1;
            end
        end else begin
            drop_err_d = drop_err_d;
        end
    end

    // State and datapath registers; reset discards all in-flight and buffered work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            bias_q       <= '0;
            sum_q        <= '0;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_acc_q   <= '0;
            pend_bias_q  <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'h00;
            sat_count_q  <= 8'h00;
            drop_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            bias_q       <= bias_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_acc_q   <= pend_acc_d;
            pend_bias_q  <= pend_bias_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sat_count_q  <= sat_count_d;
            drop_err_q   <= drop_err_d;
        end
    end

    assign acc_ready = (state_q == ST_IDLE) && !pend_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_count = sat_count_q;
    assign drop_err  = drop_err_q;

    neuron_activation_checker u_checker (
        .clk       (clk),
        .rst       (rst),
        .acc_ready (acc_ready),
        .out_valid (out_valid_q),
        .out_ready (out_ready),
        .out_data  (out_data_q),
        .drop_err  (drop_err_q)
    );

endmodule
